dport_mem_responder: RTL and testbench
======================================

DPORT_MEM_RESPONDER -- requirements
Module: dport_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, memory depth in 32-bit words (power of two, 2..65536).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; SHALL be aligned to MEM_WORDS*4.
REQ-003 Parameter WAIT_CYCLES, default 1, extra busy cycles per access (0..15).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 i_DAddr  input  32  byte address of request.
REQ-007 i_DCmd  input  1  request strobe, one cycle, sampled only while o_DRdy=1.
REQ-008 i_DRnW  input  1  1=read, 0=write.
REQ-009 i_DBen  input  4  byte enables, bit n covers data[8n+7:8n].
REQ-010 i_DData  input  32  write data.
REQ-011 o_DData  output  32  read data.
REQ-012 o_DRdy  output  1  1=idle/complete, accepting a command; 0=busy.
REQ-013 o_DErr  output  1  error status of the last completed access.

Function
REQ-014 States SHALL be IDLE and BUSY; IDLE drives o_DRdy=1, BUSY drives o_DRdy=0.
REQ-015 IDLE + i_DCmd=1 at an edge SHALL latch addr/rnw/ben/wdata, load wait counter with WAIT_CYCLES, clear o_DErr, and enter BUSY.
REQ-016 BUSY with counter>0 SHALL decrement the counter each edge; BUSY with counter=0 SHALL perform the access and return to IDLE on that edge.
REQ-017 Latency: o_DRdy SHALL be low for exactly WAIT_CYCLES+1 cycles after the accepting edge (1 cycle when WAIT_CYCLES=0).
REQ-018 i_DCmd while BUSY SHALL be ignored; no queueing, no error.
REQ-019 In range: BASE_ADDR <= addr < BASE_ADDR+MEM_WORDS*4; word index = (addr-BASE_ADDR)>>2.
REQ-020 Access with address out of range or addr[1:0]!=0 SHALL complete with o_DErr=1, SHALL NOT modify memory, and SHALL leave o_DData unchanged.
REQ-021 A valid write SHALL update only bytes whose i_DBen bit is 1, at the completion edge; i_DBen=0 SHALL be a no-op with o_DErr=0.
REQ-022 A valid read SHALL return the full 32-bit word on o_DData, regardless of i_DBen, at the completion edge.
REQ-023 o_DData and o_DErr SHALL hold their completion values until the next accepted command (o_DErr is cleared at acceptance; o_DData holds until the next valid read completes).
REQ-024 Read-after-write to the same word SHALL return the newly written bytes merged with the old unwritten bytes.
REQ-025 A command in the cycle o_DRdy returns high SHALL be accepted (back-to-back throughput one access per WAIT_CYCLES+2 cycles).

Reset
REQ-026 nrst=0 SHALL force IDLE, o_DRdy=1, o_DErr=0, o_DData=0, counter=0 immediately, without waiting for clk.
REQ-027 Reset during BUSY SHALL abort the access; a pending write SHALL NOT be committed.
REQ-028 Memory array contents SHALL NOT be reset; they are undefined until written.

Verification
REQ-029 WAIT_CYCLES=1: write 0xDEADBEEF, Ben=4'hF, addr BASE+0x10; read addr BASE+0x10 -> o_DRdy low 2 cycles each access, o_DData=0xDEADBEEF, o_DErr=0.
REQ-030 Word holds 0x11223344; write 0xAABBCCDD with Ben=4'b0101; read -> 0x11BB33DD.
REQ-031 Read at BASE+MEM_WORDS*4 and at BASE+0x2 -> o_DErr=1 on completion, o_DData unchanged, memory unchanged; next valid access clears o_DErr at acceptance.
REQ-032 WAIT_CYCLES=0: back-to-back commands, DCmd asserted every cycle -> each accepted only when o_DRdy=1, busy cycles ignored, exactly one access per 2 cycles.
REQ-033 Write issued, nrst pulsed low while BUSY -> o_DRdy=1, o_DErr=0, o_DData=0 immediately; subsequent read of that word returns the pre-write value.

Source files
------------

// File: rtl/dport_mem_responder_if.sv
// Data-port bus between a requester (master) and the memory responder (slave).
interface dport_mem_responder_if;
  logic [31:0] i_DAddr;
  logic        i_DCmd;
  logic        i_DRnW;
  logic [3:0]  i_DBen;
  logic [31:0] i_DData;
  logic [31:0] o_DData;
  logic        o_DRdy;
  logic        o_DErr;

  modport slave (
    input  i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
    output o_DData, o_DRdy, o_DErr
  );

  modport master (
    output i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
    input  o_DData, o_DRdy, o_DErr
  );
endinterface

// File: rtl/dport_mem_responder.sv
// Single-port word memory behind a data-port handshake: one command at a time,
// fixed programmable wait states, byte-enabled writes and range/alignment errors.
module dport_mem_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input logic                   clk,
  input logic                   nrst,
  dport_mem_responder_if.slave  dport
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic [3:0]  ben_q, ben_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic          accessOk;
  logic          memWe;
  logic [AW-1:0] wordIdx;

  // BASE_ADDR is aligned to the memory size, so range is a compare of the upper bits.
  assign accessOk = (addr_q[31:AW+2] == BASE_ADDR[31:AW+2]) && (addr_q[1:0] == 2'b00);
  assign wordIdx  = addr_q[AW+1:2];
  assign memWe    = (state_q == BUSY) && (cnt_q == 4'd0) && !rnw_q && accessOk;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rnw_q   <= 1'b0;
      ben_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      ben_q   <= ben_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    ben_d   = ben_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (dport.i_DCmd) begin
          addr_d  = dport.i_DAddr;
          rnw_d   = dport.i_DRnW;
          ben_d   = dport.i_DBen;
          wdata_d = dport.i_DData;
          cnt_d   = WAIT_CNT;
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          err_d   = !accessOk;
          if (accessOk && rnw_q) begin
            rdata_d = mem[wordIdx];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array is deliberately not reset; an aborted access never reaches memWe.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (ben_q[b]) begin
          mem[wordIdx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign dport.o_DRdy  = (state_q == IDLE);
  assign dport.o_DErr  = err_q;
  assign dport.o_DData = rdata_q;

endmodule

// File: tb/tb_dport_mem_responder.sv
// Scoreboard bench: two responders (1 and 0 wait states), directed accesses, monitors check completions.
module tb_dport_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  always #5 clk = ~clk;

  dport_mem_responder_if busA ();
  dport_mem_responder_if busB ();

  dport_mem_responder #(
    .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_CYCLES(1)
  ) dutA (
    .clk(clk), .nrst(nrst), .dport(busA)
  );

  dport_mem_responder #(
    .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_CYCLES(0)
  ) dutB (
    .clk(clk), .nrst(nrst), .dport(busB)
  );

  exp_t sbA[$];
  exp_t sbB[$];
  exp_t eA;
  exp_t eB;
  int   passCnt  = 0;
  int   checkCnt = 0;
  int   busyA    = 0;
  int   busyB    = 0;
  int   doneB    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Monitor A: a completion is the first idle sample after one or more busy samples.
  always @(negedge clk) begin
    if (!nrst) begin
      busyA = 0;
    end else if (!busA.o_DRdy) begin
      if (busyA == 0) checkOutput("A/errClearedAtAccept", {31'd0, busA.o_DErr}, 32'd0);
      busyA++;
    end else if (busyA > 0) begin
      if (sbA.size() == 0) begin
        checkOutput("A/unexpectedCompletion", sbA.size(), 32'd1);
      end else begin
        eA = sbA.pop_front();
        checkOutput({eA.name, "/data"}, busA.o_DData, eA.data);
        checkOutput({eA.name, "/err"}, {31'd0, busA.o_DErr}, {31'd0, eA.err});
        checkOutput({eA.name, "/busyCycles"}, busyA, 32'd2);
      end
      busyA = 0;
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      busyB = 0;
    end else if (!busB.o_DRdy) begin
      busyB++;
    end else if (busyB > 0) begin
      doneB++;
      if (sbB.size() == 0) begin
        checkOutput("B/unexpectedCompletion", sbB.size(), 32'd1);
      end else begin
        eB = sbB.pop_front();
        checkOutput({eB.name, "/data"}, busB.o_DData, eB.data);
        checkOutput({eB.name, "/err"}, {31'd0, busB.o_DErr}, {31'd0, eB.err});
        checkOutput({eB.name, "/busyCycles"}, busyB, 32'd1);
      end
      busyB = 0;
    end
  end

  task automatic waitRdyA(input string name);
    int n = 0;
    while (busA.o_DRdy !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput({name, "/rdyTimeout"}, {31'd0, busA.o_DRdy}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic rnw, input logic [3:0] ben,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic expErr, input string name);
    waitRdyA(name);
    busA.i_DAddr = addr;
    busA.i_DRnW  = rnw;
    busA.i_DBen  = ben;
    busA.i_DData = wdata;
    busA.i_DCmd  = 1'b1;
    sbA.push_back('{data: expData, err: expErr, name: name});
    @(posedge clk); #1;
    busA.i_DCmd  = 1'b0;
  endtask

  // Accept a write on A, then pulse reset while it is still waiting.
  task automatic abortWrite(input logic [31:0] addr, input logic [31:0] wdata);
    waitRdyA("A/abort");
    busA.i_DAddr = addr;
    busA.i_DRnW  = 1'b0;
    busA.i_DBen  = 4'hF;
    busA.i_DData = wdata;
    busA.i_DCmd  = 1'b1;
    @(posedge clk); #1;
    busA.i_DCmd  = 1'b0;
    checkOutput("A/abort/busyBeforeReset", {31'd0, busA.o_DRdy}, 32'd0);
    nrst = 1'b0;
    #1;
    checkOutput("A/abort/rdy", {31'd0, busA.o_DRdy}, 32'd1);
    checkOutput("A/abort/err", {31'd0, busA.o_DErr}, 32'd0);
    checkOutput("A/abort/data", busA.o_DData, 32'd0);
    #5;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busA.i_DAddr = '0; busA.i_DCmd = 1'b0; busA.i_DRnW = 1'b0; busA.i_DBen = '0; busA.i_DData = '0;
    busB.i_DAddr = '0; busB.i_DCmd = 1'b0; busB.i_DRnW = 1'b0; busB.i_DBen = '0; busB.i_DData = '0;
    #1;
    checkOutput("A/reset/rdy", {31'd0, busA.o_DRdy}, 32'd1);
    checkOutput("A/reset/err", {31'd0, busA.o_DErr}, 32'd0);
    checkOutput("A/reset/data", busA.o_DData, 32'd0);
    checkOutput("B/reset/rdy", {31'd0, busB.o_DRdy}, 32'd1);
    #11;
    nrst = 1'b1;
    @(posedge clk); #1;

    applyStimulus(BASE + 32'h10, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0000_0000, 1'b0, "A/wrFull");
    applyStimulus(BASE + 32'h10, 1'b1, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, "A/rdFull");
    applyStimulus(BASE + 32'h20, 1'b0, 4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0, "A/wrBase");
    applyStimulus(BASE + 32'h20, 1'b0, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0, "A/wrPartial");
    applyStimulus(BASE + 32'h20, 1'b1, 4'hF, 32'h0,        32'h11BB33DD, 1'b0, "A/rdMerged");
    applyStimulus(BASE + 32'h100, 1'b1, 4'hF, 32'h0,       32'h11BB33DD, 1'b1, "A/rdPastEnd");
    applyStimulus(BASE + 32'h2,  1'b1, 4'hF, 32'h0,        32'h11BB33DD, 1'b1, "A/rdMisaligned");
    applyStimulus(BASE - 32'h4,  1'b0, 4'hF, 32'hFFFFFFFF, 32'h11BB33DD, 1'b1, "A/wrBelowBase");
    applyStimulus(BASE + 32'h22, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h11BB33DD, 1'b1, "A/wrMisaligned");
    applyStimulus(BASE + 32'h20, 1'b1, 4'hF, 32'h0,        32'h11BB33DD, 1'b0, "A/rdAfterErr");
    applyStimulus(BASE + 32'h10, 1'b0, 4'h0, 32'h00000000, 32'h11BB33DD, 1'b0, "A/wrNoBen");
    applyStimulus(BASE + 32'h10, 1'b1, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, "A/rdNoBen");
    abortWrite(BASE + 32'h10, 32'hCAFEF00D);
    applyStimulus(BASE + 32'h10, 1'b1, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, "A/rdAfterAbort");
    waitRdyA("A/drain");
    repeat (3) @(posedge clk);
    #1;

    busB.i_DAddr = BASE;
    busB.i_DRnW  = 1'b0;
    busB.i_DBen  = 4'hF;
    busB.i_DData = 32'h5A5AA5A5;
    busB.i_DCmd  = 1'b1;
    sbB.push_back('{data: 32'h0, err: 1'b0, name: "B/wr"});
    @(posedge clk); #1;
    busB.i_DCmd  = 1'b0;
    @(posedge clk); #1;
    checkOutput("B/rdyAfterWrite", {31'd0, busB.o_DRdy}, 32'd1);

    // Command held high for ten edges: only the five idle edges may accept.
    busB.i_DRnW = 1'b1;
    busB.i_DCmd = 1'b1;
    for (int k = 0; k < 5; k++) sbB.push_back('{data: 32'h5A5AA5A5, err: 1'b0, name: "B/rdStream"});
    repeat (10) @(posedge clk);
    #1;
    busB.i_DCmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("A/scoreboardEmpty", sbA.size(), 32'd0);
    checkOutput("B/scoreboardEmpty", sbB.size(), 32'd0);
    checkOutput("B/completionCount", doneB, 32'd6);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
